// File: rtl/spi_ctrl_iomem_if.sv
// CPU iomem bus as seen by the SPI controller: one-cycle sel strobe,
// byte write strobes, combinational read data.
interface spi_ctrl_iomem_if;
  logic        sel;
  logic [7:0]  addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, addr, wstrb, wdata, input rdata);
  modport slave  (input sel, addr, wstrb, wdata, output rdata);
endinterface

// File: rtl/spi_ctrl_iomem.sv
// SPI mode-0 master on the iomem bus: single/dual/quad lanes, one byte per TX write.
// Quad lanes exist only when SPI_CONTROLLER_QUAD_EN is defined; otherwise MODE=10 runs single.
module spi_ctrl_iomem (
  input  logic                   clk,
  input  logic                   reset,
  spi_ctrl_iomem_if.slave        bus,
  output logic                   spi_cs,
  output logic                   spi_clk,
  input  logic [3:0]             spi_data_in,
  output logic [3:0]             spi_data_out,
  output logic [3:0]             spi_data_enable
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LAST  = 2'd2;

  localparam logic [1:0] M_SINGLE = 2'd0;
  localparam logic [1:0] M_DUAL   = 2'd1;
  localparam logic [1:0] M_QUAD   = 2'd2;

  logic [1:0] state;
  logic [7:0] ctrl;
  logic [7:0] rx;
  logic [7:0] tx_sh;
  logic       busy;
  logic       cs_pend;
  logic [3:0] div_cnt;
  logic [3:0] cur_div;
  logic [1:0] cur_mode;
  logic       cur_rd;
  logic [2:0] per_cnt;
  logic [3:0] dout_q;
  logic [3:0] den_q;

  function automatic logic [1:0] decode_mode(input logic [1:0] f);
    case (f)
      2'b01: decode_mode = M_DUAL;
      2'b10: begin
`ifdef SPI_CONTROLLER_QUAD_EN
        decode_mode = M_QUAD;
`else
        decode_mode = M_SINGLE;
`endif
      end
      default: decode_mode = M_SINGLE;
    endcase
  endfunction

  function automatic logic [3:0] lane_bits(input logic [1:0] mode, input logic [7:0] b);
    case (mode)
      M_QUAD:  lane_bits = b[7:4];
      M_DUAL:  lane_bits = {2'b00, b[7:6]};
      default: lane_bits = {3'b000, b[7]};
    endcase
  endfunction

  function automatic logic [3:0] lane_en(input logic [1:0] mode, input logic rd);
    case (mode)
      M_QUAD:  lane_en = rd ? 4'h0 : 4'hF;
      M_DUAL:  lane_en = rd ? 4'h0 : 4'h3;
      default: lane_en = 4'h1;
    endcase
  endfunction

  function automatic logic [7:0] shift_tx(input logic [1:0] mode, input logic [7:0] b);
    case (mode)
      M_QUAD:  shift_tx = {b[3:0], 4'h0};
      M_DUAL:  shift_tx = {b[5:0], 2'b00};
      default: shift_tx = {b[6:0], 1'b0};
    endcase
  endfunction

  // Single lane is always full duplex; dual/quad only shift in when RD is set.
  function automatic logic [7:0] sample_rx(input logic [1:0] mode, input logic rd,
                                           input logic [7:0] cur, input logic [3:0] din);
    case (mode)
      M_QUAD:  sample_rx = rd ? {cur[3:0], din} : cur;
      M_DUAL:  sample_rx = rd ? {cur[5:0], din[1:0]} : cur;
      default: sample_rx = {cur[6:0], din[1]};
    endcase
  endfunction

  function automatic logic [2:0] last_period(input logic [1:0] mode);
    case (mode)
      M_QUAD:  last_period = 3'd1;
      M_DUAL:  last_period = 3'd3;
      default: last_period = 3'd7;
    endcase
  endfunction

  logic       wr_hit;
  logic       ctrl_wr;
  logic       tx_wr;
  logic       csrel_wr;
  logic       start;
  logic [7:0] ctrl_nx;
  logic [1:0] mode_nx;
  logic       half_done;

  assign wr_hit    = bus.sel && (bus.addr == 8'h00);
  assign ctrl_wr   = wr_hit && bus.wstrb[1];
  assign tx_wr     = wr_hit && bus.wstrb[0];
  assign csrel_wr  = ctrl_wr && bus.wdata[15];
  // A control write in the same cycle as the TX byte configures that byte.
  assign ctrl_nx   = ctrl_wr ? bus.wdata[15:8] : ctrl;
  assign mode_nx   = decode_mode(ctrl_nx[5:4]);
  assign start     = tx_wr && !busy;
  assign half_done = (div_cnt == cur_div);

  assign bus.rdata = (bus.addr == 8'h00) ? {busy, 15'h0000, ctrl, rx} : 32'h0000_0000;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      ctrl     <= 8'h00;
      rx       <= 8'h00;
      busy     <= 1'b0;
      cs_pend  <= 1'b0;
      spi_cs   <= 1'b1;
      spi_clk  <= 1'b0;
      dout_q   <= 4'h0;
      den_q    <= 4'h0;
      div_cnt  <= 4'h0;
      cur_div  <= 4'h0;
      cur_mode <= M_SINGLE;
      cur_rd   <= 1'b0;
      per_cnt  <= 3'd0;
    end else begin
      if (ctrl_wr)
        ctrl <= bus.wdata[15:8];

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SHIFT;
            busy     <= 1'b1;
            tx_sh    <= bus.wdata[7:0];
            cur_div  <= ctrl_nx[3:0];
            cur_mode <= mode_nx;
            cur_rd   <= ctrl_nx[6];
            per_cnt  <= last_period(mode_nx);
            div_cnt  <= 4'h0;
            spi_clk  <= 1'b0;
            dout_q   <= lane_bits(mode_nx, bus.wdata[7:0]) & lane_en(mode_nx, ctrl_nx[6]);
            den_q    <= lane_en(mode_nx, ctrl_nx[6]);
          end
        end
        S_SHIFT: begin
          if (half_done) begin
            div_cnt <= 4'h0;
            if (!spi_clk) begin
              spi_clk <= 1'b1;
              rx      <= sample_rx(cur_mode, cur_rd, rx, spi_data_in);
            end else begin
              spi_clk <= 1'b0;
              if (per_cnt == 3'd0) begin
                state <= S_LAST;
              end else begin
                per_cnt <= per_cnt - 3'd1;
                tx_sh   <= shift_tx(cur_mode, tx_sh);
                dout_q  <= lane_bits(cur_mode, shift_tx(cur_mode, tx_sh)) &
                           lane_en(cur_mode, cur_rd);
              end
            end
          end else begin
            div_cnt <= div_cnt + 4'd1;
          end
        end
        S_LAST: begin
          if (half_done) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            div_cnt <= 4'h0;
            dout_q  <= 4'h0;
            den_q   <= 4'h0;
          end else begin
            div_cnt <= div_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // CS drops with each start and only rises on an explicit release.
      if (start) begin
        spi_cs  <= 1'b0;
        cs_pend <= csrel_wr;
      end else if (state == S_IDLE) begin
        if (csrel_wr || cs_pend) begin
          spi_cs  <= 1'b1;
          cs_pend <= 1'b0;
        end
      end else if (csrel_wr) begin
        cs_pend <= 1'b1;
      end
    end
  end

`ifdef SPI_CONTROLLER_QUAD_EN
  assign spi_data_out    = dout_q;
  assign spi_data_enable = den_q;
`else
  logic unused_hi_lanes;
  assign unused_hi_lanes = ^{dout_q[3:2], den_q[3:2]};
  assign spi_data_out    = {2'b00, dout_q[1:0]};
  assign spi_data_enable = {2'b00, den_q[1:0]};
`endif

  logic unused_bus;
  assign unused_bus = ^{bus.wdata[31:16], bus.wstrb[3:2]};

endmodule

// File: tb/tb_spi_ctrl_iomem.sv
// Randomized bench for spi_ctrl_iomem against a per-cycle arithmetic model of
// SPI clock timing, lane data, busy, chip select and the assembled RX byte.
module tb_spi_ctrl_iomem;

`ifdef SPI_CONTROLLER_QUAD_EN
  localparam bit QUAD_EN = 1'b1;
`else
  localparam bit QUAD_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       spi_cs;
  logic       spi_clk;
  logic [3:0] spi_data_in;
  logic [3:0] spi_data_out;
  logic [3:0] spi_data_enable;

  spi_ctrl_iomem_if bus ();

  spi_ctrl_iomem dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus.slave),
    .spi_cs          (spi_cs),
    .spi_clk         (spi_clk),
    .spi_data_in     (spi_data_in),
    .spi_data_out    (spi_data_out),
    .spi_data_enable (spi_data_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec;
  int         n_err;
  logic [7:0] model_ctrl;
  logic [7:0] model_rx;
  bit         pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int lanes_of(input logic [1:0] m);
    case (m)
      2'b01:   return 2;
      2'b10:   return QUAD_EN ? 4 : 1;
      default: return 1;
    endcase
  endfunction

  // One byte transfer. inj_kind: 0 none, 1 dropped TX write while busy, 2 CSREL while busy.
  task automatic run_xfer(input logic [7:0] c, input logic [7:0] t,
                          input logic [31:0] padw, input int inj_kind);
    int         h, L, P, total, done_c, inj_at, k;
    bit         rd;
    logic [3:0] nib, exp_out, exp_en, msk;
    logic       exp_clk;
    L      = lanes_of(c[5:4]);
    rd     = c[6] && (L > 1);
    P      = 8 / L;
    h      = int'(c[3:0]) + 1;
    total  = 2 * P * h;
    done_c = total + h;
    inj_at = (inj_kind == 0) ? -1 : int'($urandom_range(1, done_c - 1));
    msk    = 4'((1 << L) - 1);
    for (int j = 0; j < P; j++) begin
      nib = padw[4*j +: 4];
      if (L == 1)  model_rx = {model_rx[6:0], nib[1]};
      else if (rd) model_rx = 8'((model_rx << L) | {4'h0, nib & msk});
    end
    model_ctrl = c;
    if (c[7]) pend = 1'b1;

    spi_data_in = padw[3:0];
    bus.sel     = 1'b1;
    bus.addr    = 8'h00;
    bus.wstrb   = {2'($urandom), 2'b11};
    bus.wdata   = {16'($urandom), c, t};
    @(negedge clk);
    for (int cy = 0; cy <= done_c + 2; cy++) begin
      bus.sel   = 1'b0;
      bus.wstrb = 4'h0;
      k       = cy / (2 * h);
      exp_clk = (cy < total) && ((cy / h) % 2 == 1);
      chk("sclk", 32'(spi_clk), 32'(exp_clk));
      chk("busy", 32'(bus.rdata[31]), 32'(cy < done_c));
      chk("cs", 32'(spi_cs), 32'(pend && (cy > done_c)));
      if (cy < total) begin
        exp_en  = rd ? 4'h0 : msk;
        exp_out = rd ? 4'h0 : 4'((int'(t) >> (8 - L * (k + 1))) & int'(msk));
        chk("dout", 32'(spi_data_out), 32'(exp_out));
        chk("den", 32'(spi_data_enable), 32'(exp_en));
      end
      if ((cy % (2 * h) == h) && (k + 1 < P))
        spi_data_in = padw[4*(k+1) +: 4];
      if (cy == inj_at) begin
        bus.sel  = 1'b1;
        bus.addr = 8'h00;
        if (inj_kind == 1) begin
          bus.wstrb = 4'b0001;
          bus.wdata = {24'h0, 8'($urandom)};
        end else begin
          model_ctrl = model_ctrl | 8'h80;
          pend       = 1'b1;
          bus.wstrb  = 4'b0010;
          bus.wdata  = {16'h0, model_ctrl, 8'h00};
        end
      end
      @(negedge clk);
    end
    chk("rdata", bus.rdata, {1'b0, 15'h0, model_ctrl, model_rx});
    pend = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_cs"}, 32'(spi_cs), 32'd1);
    chk({tag, "_sclk"}, 32'(spi_clk), 32'd0);
    chk({tag, "_dout"}, 32'(spi_data_out), 32'd0);
    chk({tag, "_den"}, 32'(spi_data_enable), 32'd0);
    chk({tag, "_rdata"}, bus.rdata, 32'd0);
  endtask

  initial begin
    logic [7:0] c;
    n_vec       = 0;
    n_err       = 0;
    model_ctrl  = 8'h00;
    model_rx    = 8'h00;
    pend        = 1'b0;
    reset       = 1'b0;
    spi_data_in = 4'h0;
    bus.sel     = 1'b0;
    bus.addr    = 8'h00;
    bus.wstrb   = 4'h0;
    bus.wdata   = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("idle");

    // Dual write, DIV=2: pairs 10,10,01,01.
    run_xfer(8'h12, 8'hA5, $urandom, 0);
    // Single, DIV=15, IO1 held high.
    run_xfer(8'h4F, 8'h5A, 32'hFFFF_FFFF, 0);

    // CS release on its own while idle.
    bus.sel = 1'b1; bus.addr = 8'h00; bus.wstrb = 4'b0010; bus.wdata = 32'h0000_9200;
    @(negedge clk);
    bus.sel = 1'b0; bus.wstrb = 4'h0;
    model_ctrl = 8'h92;
    chk("csrel_cs", 32'(spi_cs), 32'd1);
    repeat (4) begin
      chk("csrel_sclk", 32'(spi_clk), 32'd0);
      chk("csrel_rdata", bus.rdata, {16'h0, model_ctrl, model_rx});
      @(negedge clk);
    end

    // Other addresses read zero and ignore writes.
    bus.addr = 8'h04;
    #1 chk("addr4_rd", bus.rdata, 32'd0);
    bus.sel = 1'b1; bus.wstrb = 4'b1111; bus.wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.sel = 1'b0; bus.wstrb = 4'h0; bus.addr = 8'h00;
    #1 chk("addr4_wr", bus.rdata, {16'h0, model_ctrl, model_rx});
    chk("addr4_busy", 32'(spi_clk), 32'd0);

    // Quad read, DIV=0, pad nibbles C then 3.
    run_xfer(8'h60, 8'h00, 32'h0000_003C, 0);
    // Dropped TX while busy, then CSREL while busy, then CSREL together with TX.
    run_xfer(8'h13, 8'h3C, $urandom, 1);
    run_xfer(8'h01, 8'hC3, $urandom, 2);
    run_xfer(8'h81, 8'h96, $urandom, 0);

    for (int n = 0; n < 30; n++) begin
      c = 8'($urandom);
      c[7] = ($urandom_range(0, 3) == 0);
      run_xfer(c, 8'($urandom), $urandom, int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a byte.
    bus.sel = 1'b1; bus.addr = 8'h00; bus.wstrb = 4'b0011; bus.wdata = 32'h0000_0255;
    @(negedge clk);
    bus.sel = 1'b0; bus.wstrb = 4'h0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("abort");
    repeat (3) begin
      @(negedge clk);
      chk("abort_sclk", 32'(spi_clk), 32'd0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
